// File: rtl/jogo_sequencia_param.sv
// rtl/jogo_sequencia_param.sv - memory-game top: FSM, position/round counters, play timer, play register
// Play edges come from the switch bank and are checked against a combinational-read sequence ROM.
module jogo_sequencia_param #(
  parameter int N_CHAVES = 4,
  parameter int ADDR_W   = 4,
  parameter int PROF     = 16,
  parameter int TIMEOUT  = 3000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  input  logic [N_CHAVES-1:0] dado_mem,
  output logic [ADDR_W-1:0]   endereco,
  output logic [ADDR_W-1:0]   rodada,
  output logic [N_CHAVES-1:0] leds,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                db_igual,
  output logic                db_tem_jogada,
  output logic [3:0]          db_estado
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIM   = TIMER_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]  ULTIMA_RODADA = ADDR_W'(PROF - 1);

  typedef enum logic [3:0] {
    inicial     = 4'h0,
    preparacao  = 4'h1,
    espera      = 4'h2,
    compara     = 4'h4,
    prox_jogada = 4'h5,
    prox_rodada = 4'h6,
    fim_acerto  = 4'hA,
    fim_timeout = 4'hD,
    fim_erro    = 4'hE
  } estado_t;

  estado_t state, next_state;

  logic [ADDR_W-1:0]   posicao;
  logic [ADDR_W-1:0]   rodada_q;
  logic [N_CHAVES-1:0] jogada;
  logic [N_CHAVES-1:0] chaves_prev;
  logic [TIMER_W-1:0]  timer;

  logic jogada_feita;
  logic igual;
  logic fim_tempo;

  // Datapath controls produced by the FSM
  logic zera_tudo;
  logic carrega_jogada;
  logic zera_timer;
  logic conta_timer;
  logic inc_posicao;
  logic inc_rodada;

  assign jogada_feita = (chaves != '0) && (chaves_prev == '0);
  assign igual        = (jogada == dado_mem);
  assign fim_tempo    = (timer == TIMER_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= inicial;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    zera_tudo      = 1'b0;
    carrega_jogada = 1'b0;
    zera_timer     = 1'b0;
    conta_timer    = 1'b0;
    inc_posicao    = 1'b0;
    inc_rodada     = 1'b0;
    case (state)
      inicial: begin
        if (iniciar) next_state = preparacao;
      end
      preparacao: begin
        zera_tudo  = 1'b1;
        next_state = espera;
      end
      espera: begin
        // A play arriving on the last timer cycle still counts
        if (jogada_feita) begin
          carrega_jogada = 1'b1;
          zera_timer     = 1'b1;
          next_state     = compara;
        end else if (fim_tempo) begin
          next_state = fim_timeout;
        end else begin
          conta_timer = 1'b1;
        end
      end
      compara: begin
        if (!igual)                      next_state = fim_erro;
        else if (posicao != rodada_q)    next_state = prox_jogada;
        else if (rodada_q == ULTIMA_RODADA) next_state = fim_acerto;
        else                             next_state = prox_rodada;
      end
      prox_jogada: begin
        inc_posicao = 1'b1;
        zera_timer  = 1'b1;
        next_state  = espera;
      end
      prox_rodada: begin
        inc_rodada = 1'b1;
        zera_timer = 1'b1;
        next_state = espera;
      end
      fim_acerto, fim_erro, fim_timeout: begin
        if (iniciar) next_state = preparacao;
      end
      default: next_state = inicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      posicao     <= '0;
      rodada_q    <= '0;
      jogada      <= '0;
      chaves_prev <= '0;
      timer       <= '0;
    end else begin
      chaves_prev <= chaves;
      if (zera_tudo) begin
        posicao  <= '0;
        rodada_q <= '0;
        jogada   <= '0;
        timer    <= '0;
      end else begin
        if (carrega_jogada) jogada <= chaves;
        if (zera_timer)       timer <= '0;
        else if (conta_timer) timer <= timer + 1'b1;
        if (inc_posicao) posicao <= posicao + 1'b1;
        if (inc_rodada) begin
          rodada_q <= rodada_q + 1'b1;
          posicao  <= '0;
        end
      end
    end
  end

  always_comb begin
    pronto  = 1'b0;
    acertou = 1'b0;
    errou   = 1'b0;
    timeout = 1'b0;
    case (state)
      fim_acerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      fim_erro: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      fim_timeout: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign endereco      = posicao;
  assign rodada        = rodada_q;
  assign leds          = jogada;
  assign db_igual      = igual;
  assign db_tem_jogada = jogada_feita;
  assign db_estado     = state;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb/tb_jogo_sequencia_param.sv - directed bench for jogo_sequencia_param
// Instance b (long timeout) plays the game; instance a (TIMEOUT=10) covers the timer paths.
module tb_jogo_sequencia_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar_a = 1'b0, iniciar_b = 1'b0;
  logic [3:0] chaves_a = '0, chaves_b = '0;
  logic [3:0] dado_a, dado_b;
  logic [3:0] end_a, end_b, rod_a, rod_b, leds_a, leds_b, est_a, est_b;
  logic       pronto_a, pronto_b, acertou_a, acertou_b, errou_a, errou_b;
  logic       to_a, to_b, igual_a, igual_b, tem_a, tem_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  function automatic logic [3:0] rom(input logic [3:0] addr);
    case (addr)
      4'd0: rom = 4'd1;
      4'd1: rom = 4'd2;
      4'd2: rom = 4'd4;
      4'd3: rom = 4'd8;
      default: rom = 4'd0;
    endcase
  endfunction

  assign dado_a = rom(end_a);
  assign dado_b = rom(end_b);

  jogo_sequencia_param #(.N_CHAVES(4), .ADDR_W(4), .PROF(4), .TIMEOUT(10)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar_a), .chaves(chaves_a), .dado_mem(dado_a),
    .endereco(end_a), .rodada(rod_a), .leds(leds_a), .pronto(pronto_a), .acertou(acertou_a),
    .errou(errou_a), .timeout(to_a), .db_igual(igual_a), .db_tem_jogada(tem_a), .db_estado(est_a)
  );

  jogo_sequencia_param #(.N_CHAVES(4), .ADDR_W(4), .PROF(4), .TIMEOUT(3000)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .chaves(chaves_b), .dado_mem(dado_b),
    .endereco(end_b), .rodada(rod_b), .leds(leds_b), .pronto(pronto_b), .acertou(acertou_b),
    .errou(errou_b), .timeout(to_b), .db_igual(igual_b), .db_tem_jogada(tem_b), .db_estado(est_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_b(input logic [3:0] v);
    chaves_b = v;
    tick(3);
    chaves_b = '0;
    tick(3);
  endtask

  task automatic start_b();
    iniciar_b = 1'b1;
    tick(1);
    iniciar_b = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_estado", est_b, 4'h0);
    check("rst_rodada", rod_b, 4'h0);
    check("rst_endereco", end_b, 4'h0);
    check("rst_leds", leds_b, 4'h0);
    check("rst_flags", {pronto_b, acertou_b, errou_b, to_b, tem_b}, 5'b0);
    check("rst_igual", igual_b, 1'b0);
    reset = 1'b1;
    tick(1);
    check("idle_holds", est_b, 4'h0);

    // Full game: 1 | 1,2 | 1,2,4 | 1,2,4,8
    iniciar_b = 1'b1;
    tick(1);
    check("prep_state", est_b, 4'h1);
    iniciar_b = 1'b0;
    tick(1);
    check("espera_state", est_b, 4'h2);
    chaves_b = 4'd1;
    #1;
    check("edge_seen", tem_b, 1'b1);
    tick(1);
    check("compara_k1", est_b, 4'h4);
    check("leds_loaded", leds_b, 4'd1);
    check("edge_once", tem_b, 1'b0);
    tick(1);
    check("prox_rodada_k2", est_b, 4'h6);
    tick(1);
    check("espera_k3", est_b, 4'h2);
    check("rodada_1", rod_b, 4'd1);
    chaves_b = '0;
    tick(3);
    press_b(4'd1);
    check("pos_1", end_b, 4'd1);
    press_b(4'd2);
    check("rodada_2", rod_b, 4'd2);
    check("pos_reset", end_b, 4'd0);
    press_b(4'd1);
    press_b(4'd2);
    press_b(4'd4);
    check("rodada_3", rod_b, 4'd3);
    press_b(4'd1);
    press_b(4'd2);
    press_b(4'd4);
    press_b(4'd8);
    check("win_estado", est_b, 4'hA);
    check("win_flags", {pronto_b, acertou_b, errou_b, to_b}, 4'b1100);
    check("win_rodada", rod_b, 4'd3);
    tick(3);
    check("win_hold", est_b, 4'hA);

    // Wrong play in round 1
    iniciar_b = 1'b1;
    tick(1);
    iniciar_b = 1'b0;
    tick(1);
    check("restart_rodada", rod_b, 4'd0);
    press_b(4'd1);
    press_b(4'd1);
    press_b(4'd4);
    check("err_estado", est_b, 4'hE);
    check("err_flags", {pronto_b, acertou_b, errou_b, to_b}, 4'b1010);
    check("err_rodada", rod_b, 4'd1);
    check("err_endereco", end_b, 4'd1);
    check("err_leds", leds_b, 4'd4);
    check("err_igual", igual_b, 1'b0);

    // Restart from fim_erro
    iniciar_b = 1'b1;
    tick(1);
    check("err_to_prep", est_b, 4'h1);
    iniciar_b = 1'b0;
    tick(1);
    check("prep_rodada", rod_b, 4'd0);
    check("prep_pos", end_b, 4'd0);
    check("prep_leds", leds_b, 4'd0);

    // Held key counts once
    chaves_b = 4'd1;
    tick(20);
    check("hold_estado", est_b, 4'h2);
    check("hold_rodada", rod_b, 4'd1);
    check("hold_pos", end_b, 4'd0);
    chaves_b = '0;
    tick(3);
    press_b(4'd1);
    check("repress_pos", end_b, 4'd1);
    check("repress_estado", est_b, 4'h2);

    // Reset mid-round 2
    press_b(4'd2);
    check("mid_rodada2", rod_b, 4'd2);
    press_b(4'd1);
    check("mid_pos1", end_b, 4'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_estado", est_b, 4'h0);
    check("async_rodada", rod_b, 4'd0);
    check("async_pos", end_b, 4'd0);
    check("async_leds", leds_b, 4'd0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Timeout exactly 10 cycles after entering espera
    iniciar_a = 1'b1;
    tick(1);
    iniciar_a = 1'b0;
    tick(1);
    check("a_espera", est_a, 4'h2);
    tick(9);
    check("a_before_to", est_a, 4'h2);
    tick(1);
    check("a_to_estado", est_a, 4'hD);
    check("a_to_flags", {pronto_a, acertou_a, errou_a, to_a}, 4'b1011);
    tick(4);
    check("a_to_hold", est_a, 4'hD);

    // Play on the last timer cycle wins
    iniciar_a = 1'b1;
    tick(1);
    iniciar_a = 1'b0;
    tick(1);
    tick(9);
    check("a_limit_espera", est_a, 4'h2);
    chaves_a = 4'd1;
    tick(1);
    check("a_limit_compara", est_a, 4'h4);
    tick(1);
    check("a_limit_prox", est_a, 4'h6);
    tick(1);
    check("a_limit_back", est_a, 4'h2);
    check("a_limit_rodada", rod_a, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
